// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals of the load/store unit.
// master = execute stage plus memory model side, slave = the load/store unit.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_rw, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_rw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, sub-word stores as read-modify-write.
// Accept-to-response 2 cycles (load/SW), 3 (SB/SH), 1 (error); req_ready low until back in IDLE.
module load_store_unit #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t            state;
    logic              store_q;
    logic [2:0]        funct3_q;
    logic [1:0]        offset_q;
    logic [31:0]       wdata_q;

    logic              ready_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;
    logic              mem_rw_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic              illegal;
    logic              misaligned;
    logic              acc_err;

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_rw     = mem_rw_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (bus.req_store) begin
            illegal = (bus.req_funct3 != 3'b000) && (bus.req_funct3 != 3'b001) &&
                      (bus.req_funct3 != 3'b010);
        end else begin
            illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                      (bus.req_funct3 == 3'b111);
        end
        misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_funct3 == 3'b010) && (bus.req_addr[1:0] != 2'b00));
        acc_err    = illegal || misaligned;
    end

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  offset);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] result;
        case (offset)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  result = {{24{lane_b[7]}}, lane_b};
            3'b001:  result = {{16{lane_h[15]}}, lane_h};
            3'b010:  result = word;
            3'b100:  result = {24'd0, lane_b};
            3'b101:  result = {16'd0, lane_h};
            default: result = 32'd0;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  offset,
                                                input logic [31:0] wdata);
        logic [31:0] result;
        result = word;
        if (funct3[1:0] == 2'b00) begin
            case (offset)
                2'd0:    result[7:0]   = wdata[7:0];
                2'd1:    result[15:8]  = wdata[7:0];
                2'd2:    result[23:16] = wdata[7:0];
                default: result[31:24] = wdata[7:0];
            endcase
        end else if (funct3[1:0] == 2'b01) begin
            if (offset[1]) result[31:16] = wdata[15:0];
            else           result[15:0]  = wdata[15:0];
        end else begin
            result = wdata;
        end
        return result;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            store_q      <= 1'b0;
            funct3_q     <= 3'd0;
            offset_q     <= 2'd0;
            wdata_q      <= 32'd0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            mem_rw_q     <= 1'b1;
            mem_addr_q   <= RESET_ADDR;
            mem_wdata_q  <= 32'd0;
        end else begin
            resp_valid_q <= 1'b0;
            mem_rw_q     <= 1'b1;
            mem_wdata_q  <= 32'd0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        store_q  <= bus.req_store;
                        funct3_q <= bus.req_funct3;
                        offset_q <= bus.req_addr[1:0];
                        wdata_q  <= bus.req_wdata;
                        ready_q  <= 1'b0;
                        if (acc_err) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'd0;
                        end else begin
                            mem_addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            if (bus.req_store && (bus.req_funct3 == 3'b010)) begin
                                state       <= WR;
                                mem_rw_q    <= 1'b0;
                                mem_wdata_q <= bus.req_wdata;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD: begin
                    // The read word is captured already merged, straight into the write-data register.
                    if (store_q) begin
                        state       <= WR;
                        mem_rw_q    <= 1'b0;
                        mem_wdata_q <= store_merge(bus.mem_rdata, funct3_q, offset_q, wdata_q);
                    end else begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_extend(bus.mem_rdata, funct3_q, offset_q);
                    end
                end
                WR: begin
                    state        <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'd0;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-abort and back-to-back sequences,
// then random requests against a word-array reference model.
module tb_load_store_unit;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(.ADDR_W(ADDR_W), .RESET_ADDR('0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        pre_en;
    logic [5:0]  pre_idx;
    logic [31:0] pre_val;

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (!bus.mem_rw) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = idx[5:0];
        pre_val = val;
        ref_mem[idx] = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic run_req(input bit st, input logic [2:0] f3, input logic [7:0] a,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd,
                           output logic er, output int nwr, output logic [31:0] wa,
                           output logic [31:0] wdat, output int rdy_hi);
        int w;
        lat = 0; rd = '0; er = 1'b0; nwr = 0; wa = '0; wdat = '0; rdy_hi = 0;
        @(negedge clk);
        w = 0;
        while (!bus.req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_req", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = {24'd0, a};
        bus.req_wdata  = wd;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_valid = 1'b0;
            if (!bus.mem_rw) begin
                nwr++;
                wa   = bus.mem_addr;
                wdat = bus.mem_wdata;
            end
            if (bus.req_ready) rdy_hi++;
            if (bus.resp_valid) begin
                lat = c;
                rd  = bus.resp_rdata;
                er  = bus.resp_err;
                break;
            end
        end
    endtask

    task automatic apply(input string tag, input bit st, input logic [2:0] f3,
                         input logic [7:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err, input int exp_lat, input logic [31:0] exp_wword);
        int lat, nwr, rdy_hi, exp_nwr;
        logic [31:0] rd, wa, wdat;
        logic er;
        run_req(st, f3, a, wd, lat, rd, er, nwr, wa, wdat, rdy_hi);
        exp_nwr = (st && !exp_err) ? 1 : 0;
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        chk({tag, "_busy_ready"}, rdy_hi, 0);
        chk({tag, "_writes"}, nwr, exp_nwr);
        if (exp_nwr == 1) begin
            chk({tag, "_waddr"}, wa, {24'd0, a[7:2], 2'b00});
            chk({tag, "_wdata"}, wdat, exp_wword);
        end
        @(negedge clk);
        chk({tag, "_resp_drop"}, {31'd0, bus.resp_valid}, 32'd0);
        chk({tag, "_rdata_hold"}, bus.resp_rdata, exp_rd);
    endtask

    // Reference: access size from funct3, legality from size/alignment, values by shift-and-mask arithmetic.
    task automatic model(input bit st, input logic [2:0] f3, input logic [7:0] a,
                         input logic [31:0] wd, input logic [31:0] word, output logic [31:0] rd,
                         output logic er, output int lat, output logic [31:0] wword);
        int size, off;
        longint m, v, t;
        case (f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        er = (size == 0) || (f3[2] && (st || size == 4)) || (size != 0 && (int'(a) % size) != 0);
        off   = int'(a) % 4;
        rd    = '0;
        wword = word;
        lat   = er ? 1 : ((!st || size == 4) ? 2 : 3);
        if (!er) begin
            m = (longint'(1) << (8 * size)) - 1;
            if (!st) begin
                v = (longint'(word) >> (8 * off)) & m;
                if (!f3[2] && size < 4 && v >= (m + 1) / 2) v = v - (m + 1);
                rd = v[31:0];
            end else begin
                t = (longint'(word) & ~(m << (8 * off))) | ((longint'(wd) & m) << (8 * off));
                wword = t[31:0];
            end
        end
    endtask

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [31:0] pre;
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic [31:0] wword;
    } vec_t;

    vec_t tbl [17];

    task automatic check_reset_state(input string tag);
        chk({tag, "_mem_rw"}, {31'd0, bus.mem_rw}, 32'd1);
        chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        chk({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        chk({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
        chk({tag, "_resp_err"}, {31'd0, bus.resp_err}, 32'd0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    initial begin
        logic [31:0] rd, wword;
        logic er;
        int lat;
        bit st;
        logic [2:0] f3;
        logic [7:0] a;
        logic [31:0] wd;
        int r;
        logic rdy [1:5];
        logic rv [1:5];
        logic [31:0] rdat [1:5];

        rst = 1'b1;
        pre_en = 1'b0; pre_idx = '0; pre_val = '0;
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0;

        tbl[0]  = '{1'b0, 3'b010, 8'h10, 32'h0,        32'h8899AABB, 32'h8899AABB, 1'b0, 2, 32'h0};
        tbl[1]  = '{1'b0, 3'b000, 8'h13, 32'h0,        32'h80112233, 32'hFFFFFF80, 1'b0, 2, 32'h0};
        tbl[2]  = '{1'b0, 3'b100, 8'h13, 32'h0,        32'h80112233, 32'h00000080, 1'b0, 2, 32'h0};
        tbl[3]  = '{1'b0, 3'b101, 8'h12, 32'h0,        32'h80112233, 32'h00008011, 1'b0, 2, 32'h0};
        tbl[4]  = '{1'b0, 3'b001, 8'h12, 32'h0,        32'h80112233, 32'hFFFF8011, 1'b0, 2, 32'h0};
        tbl[5]  = '{1'b0, 3'b000, 8'h11, 32'h0,        32'h80112233, 32'h00000022, 1'b0, 2, 32'h0};
        tbl[6]  = '{1'b0, 3'b011, 8'h10, 32'h0,        32'h80112233, 32'h00000000, 1'b1, 1, 32'h0};
        tbl[7]  = '{1'b1, 3'b000, 8'h21, 32'h0000005A, 32'h11223344, 32'h00000000, 1'b0, 3, 32'h11225A44};
        tbl[8]  = '{1'b1, 3'b001, 8'h22, 32'h0000BEEF, 32'h11223344, 32'h00000000, 1'b0, 3, 32'hBEEF3344};
        tbl[9]  = '{1'b1, 3'b000, 8'h23, 32'hFFFFFFAB, 32'h11223344, 32'h00000000, 1'b0, 3, 32'hAB223344};
        tbl[10] = '{1'b0, 3'b101, 8'h10, 32'h0,        32'h80112233, 32'h00002233, 1'b0, 2, 32'h0};
        tbl[11] = '{1'b0, 3'b001, 8'h41, 32'h0,        32'h12345678, 32'h00000000, 1'b1, 1, 32'h0};
        tbl[12] = '{1'b1, 3'b010, 8'h30, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 1'b0, 2, 32'hDEADBEEF};
        tbl[13] = '{1'b1, 3'b010, 8'h42, 32'hCAFEF00D, 32'h12345678, 32'h00000000, 1'b1, 1, 32'h0};
        tbl[14] = '{1'b1, 3'b100, 8'h20, 32'h000000FF, 32'h11223344, 32'h00000000, 1'b1, 1, 32'h0};
        tbl[15] = '{1'b0, 3'b010, 8'h12, 32'h0,        32'h8899AABB, 32'h00000000, 1'b1, 1, 32'h0};
        tbl[16] = '{1'b1, 3'b001, 8'h23, 32'h0000BEEF, 32'h11223344, 32'h00000000, 1'b1, 1, 32'h0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            preload(int'(tbl[i].a[7:2]), tbl[i].pre);
            apply($sformatf("vec%0d", i), tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd,
                  tbl[i].rd, tbl[i].err, tbl[i].lat, tbl[i].wword);
        end

        // Reset while an SB sits in its read cycle: no write may escape.
        preload(8, 32'h11223344);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h21; bus.req_wdata = 32'h5A;
        @(posedge clk);
        @(negedge clk);
        chk("abort_rd_mem_rw", {31'd0, bus.mem_rw}, 32'd1);
        chk("abort_rd_mem_addr", bus.mem_addr, 32'h20);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("abort");
        rst = 1'b0;
        @(negedge clk);
        chk("abort_mem_intact", mem[8], 32'h11223344);

        // Back-to-back loads with req_valid held high.
        preload(4, 32'h01234567);
        preload(5, 32'h89ABCDEF);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = 3'b010;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_addr = 32'h14;
            rdy[c]  = bus.req_ready;
            rv[c]   = bus.resp_valid;
            rdat[c] = bus.resp_rdata;
        end
        bus.req_valid = 1'b0;
        chk("b2b_ready_c1", {31'd0, rdy[1]}, 32'd0);
        chk("b2b_ready_c2", {31'd0, rdy[2]}, 32'd0);
        chk("b2b_resp_c1", {31'd0, rv[1]}, 32'd0);
        chk("b2b_resp_c2", {31'd0, rv[2]}, 32'd1);
        chk("b2b_rdata_first", rdat[2], 32'h01234567);
        chk("b2b_ready_c3", {31'd0, rdy[3]}, 32'd1);
        chk("b2b_ready_c4", {31'd0, rdy[4]}, 32'd0);
        chk("b2b_resp_c4", {31'd0, rv[4]}, 32'd0);
        chk("b2b_resp_c5", {31'd0, rv[5]}, 32'd1);
        chk("b2b_rdata_second", rdat[5], 32'h89ABCDEF);

        for (int i = 0; i < 64; i++) preload(i, $urandom);

        for (int i = 0; i < 300; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 8'($urandom_range(0, 255));
            r  = int'($urandom_range(0, 3));
            if (r == 1) a[0] = 1'b0;
            if (r == 2) a[1:0] = 2'b00;
            wd = $urandom;
            model(st, f3, a, wd, ref_mem[a[7:2]], rd, er, lat, wword);
            apply($sformatf("rnd%0d", i), st, f3, a, wd, rd, er, lat, wword);
            if (st && !er) ref_mem[a[7:2]] = wword;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the data-memory interface. Accepts one load/store request at a time from the execute stage and drives the memory port. The memory port has a read/write select, an address, write data and combinational read data, and every write updates all 4 bytes. Byte and halfword stores are therefore done as read-modify-write. Loads return lane-selected, sign- or zero-extended data with a single-cycle response strobe.

Parameters:
ADDR_W, 32, width of byte address on both sides
RESET_ADDR, 0, value driven on mem_addr when idle/reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  LSU can accept (high only in IDLE)
req_store  in  1  1 = store, 0 = load
req_funct3  in  3  RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, in low bits
resp_valid  out  1  one-cycle completion strobe
resp_rdata  out  32  extended load data (0 for stores/errors)
resp_err  out  1  misaligned or illegal funct3, valid with resp_valid
mem_rw  out  1  1 = read, 0 = write (memory writes on every clk edge while low)
mem_addr  out  ADDR_W  word-aligned address (low 2 bits always 0)
mem_wdata  out  32  full word to write
mem_rdata  in  32  combinational read data for mem_addr

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_rw=1; mem_addr=RESET_ADDR; mem_wdata=0. Reset in any state aborts the access with no write issued.
- mem_rw is low only in state WR, for exactly one cycle per store. mem_rw is 1 in all other states, including reset.
- Accept: a request is taken on the edge where req_valid & req_ready. The LSU latches store flag, funct3, addr and wdata. req_ready drops the next cycle and returns high when the state goes back to IDLE after RESP. No pipelining; at most one outstanding request.
- Legality is checked at accept:
  - Illegal funct3: loads 011/110/111; stores with funct3 other than 000/001/010.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0.
  - Either case goes to RESP with resp_err=1 and resp_rdata=0. No memory access.
- States: IDLE, RD, WR, RESP.
  - Load, legal: IDLE -> RD -> RESP.
  - SW, legal: IDLE -> WR -> RESP. The RD state is skipped.
  - SB/SH, legal: IDLE -> RD -> WR -> RESP.
  - Error: IDLE -> RESP.
  - RESP -> IDLE, always.
- RD: mem_addr = {addr[ADDR_W-1:2],2'b00}, mem_rw=1. mem_rdata is captured into an internal word register at the end of the cycle.
- WR: same mem_addr, mem_rw=0.
  - SW: mem_wdata = req_wdata.
  - SB: the captured word with the lane at addr[1:0] replaced by wdata[7:0].
  - SH: the captured word with the halfword at addr[1] replaced by wdata[15:0].
- RESP: resp_valid=1 for exactly one cycle.
  - Loads: byte lane addr[1:0] or halfword lane addr[1], extended per funct3 (B/H sign-extend, BU/HU zero-extend, W passthrough).
  - Stores: resp_rdata=0.
  - resp_rdata and resp_err hold their value until the next RESP; resp_valid is 0 outside RESP.
- Latency from the accept edge to the resp_valid cycle:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- Outside RD/WR: mem_addr holds its last value and mem_wdata=0.
- req_valid held high during a busy period is ignored. The next accept happens on the first edge where the LSU is back in IDLE.

Test Plan:
- LW addr 0x10, mem word 0x8899AABB -> resp_valid 2 cycles after accept, resp_rdata=0x8899AABB, resp_err=0, mem_rw never low.
- LB addr 0x13, mem[0x10]=0x80112233 -> resp_rdata=0xFFFFFF80. LBU same addr -> 0x00000080. LHU addr 0x12 -> 0x00008011.
- SB addr 0x21 wdata 0x0000005A, mem[0x20]=0x11223344 -> RD then one WR cycle, mem_addr=0x20, mem_wdata=0x11225A44, resp 3 cycles after accept. SH addr 0x22 wdata 0xBEEF -> write 0xBEEF3344.
- LH addr 0x41 and SW addr 0x42 -> resp_err=1 one cycle after accept, resp_rdata=0, mem_rw stays 1 throughout.
- SB accepted, rst asserted on the RD cycle -> no cycle with mem_rw=0, all outputs at reset values next cycle, req_ready=1.
- req_valid held high for two back-to-back LWs -> second accept occurs only after resp_valid of the first; req_ready=0 throughout the busy period.
